// File: rtl/uart_rx_8bytes.sv
// uart_rx_8bytes
//   Oversampling 8N1 UART receiver and the receiving end of the 8-byte frame
//   link. Each received byte is stored in a small buffer at its position in
//   the frame. Frame completion, bad stop bits and inter-byte timeouts are
//   reported as single-cycle pulses.
//
// Parameters
//   OVS      clk cycles per bit (even, 4..64)
//   BYTES    bytes per frame (1..8)
//   TIMEOUT  idle clk cycles allowed between bytes of one frame
//
// Ports
//   clk         sampling clock, OVS x bit rate
//   reset       synchronous, active-low
//   rx          asynchronous serial line, idle high
//   byte_data   last received byte
//   byte_valid  pulse: byte_data/byte_idx valid
//   byte_idx    frame position of that byte
//   frame_done  pulse with the valid of the last byte of a frame
//   frame_err   pulse on a bad stop bit
//   timeout     pulse when a partial frame is discarded
//   busy        high while a byte (or a break) is in progress
//   rd_addr     buffer read address
//   rd_data     buffer read data, one cycle after rd_addr
module uart_rx_8bytes #(
  parameter int OVS     = 16,
  parameter int BYTES   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [2:0] byte_idx,
  output logic       frame_done,
  output logic       frame_err,
  output logic       timeout,
  output logic       busy,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int CW  = $clog2(OVS);
  localparam int TCW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0]  HALF_LAST = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(OVS - 1);
  localparam logic [TCW-1:0] TO_LAST   = TCW'(TIMEOUT - 1);
  localparam logic [2:0]     IDX_LAST  = 3'(BYTES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [2:0]     state;
  logic           rx_m;
  logic           rx_s;
  logic           rx_prev;
  logic [CW-1:0]  cnt;
  logic [2:0]     bitn;
  logic [7:0]     shreg;
  logic [2:0]     idx;
  logic [TCW-1:0] tcnt;
  logic [7:0]     mem [8];
  logic           start_edge;
  logic           wr_en;

  // Two-flop synchroniser for the asynchronous line, plus one extra stage of
  // history so a falling edge can be recognised. All reset to the idle level
  // so a line that is low out of reset is not mistaken for a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // First low cycle after a high one; only acted upon in IDLE.
  assign start_edge = rx_prev & ~rx_s;

  // A good stop bit stores the assembled byte. Gating with reset keeps a
  // reset that lands on the stop sample from writing the buffer.
  assign wr_en = reset && (state == S_STOP) && (cnt == BIT_LAST) && rx_s;

  assign busy = (state != S_IDLE);

  // Receive state machine. The bit counter is cleared once at the start edge
  // and then free-runs in whole-bit steps, so every sample lands mid-bit
  // without re-synchronising inside a byte. The inter-byte timeout counter
  // lives here too because it shares the start edge and idx.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bitn       <= '0;
      shreg      <= '0;
      idx        <= '0;
      tcnt       <= '0;
      byte_data  <= '0;
      byte_idx   <= '0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state <= S_START;
            cnt   <= '0;
            bitn  <= '0;
            tcnt  <= '0;
          end else if (idx != 3'd0) begin
            if (tcnt == TO_LAST) begin
              tcnt    <= '0;
              idx     <= '0;
              timeout <= 1'b1;
            end else begin
              tcnt <= tcnt + TCW'(1);
            end
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[7:1]};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              byte_data  <= shreg;
              byte_idx   <= idx;
              byte_valid <= 1'b1;
              if (idx == IDX_LAST) begin
                frame_done <= 1'b1;
                idx        <= '0;
              end else begin
                idx <= idx + 3'd1;
              end
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              idx       <= '0;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Frame buffer write. Contents deliberately survive reset so a consumer
  // can still read the last frame after a reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= shreg;
  end

  // Registered read port; a same-cycle write to rd_addr returns old data.
  always_ff @(posedge clk) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: doc/uart_rx_8bytes.md
Name: uart_rx_8bytes

Overview:
- Oversampling UART receiver and the receiving end of the team's 8-byte UART frame link.
- Deserialises 8N1 bytes from a single serial line and places them into an 8-entry byte buffer indexed by position in the frame.
- Flags frame completion, framing errors and inter-byte timeouts.
- Sits behind the RS-485 transceiver's RO output; downstream logic reads the buffer after frame_done.

Parameters:
- OVS, 16, clk cycles per bit; must be even, range 4..64.
- BYTES, 8, bytes per frame; the index is 3 bits wide, so the legal range is 1..8.
- TIMEOUT, 4096, idle clk cycles allowed between bytes of one frame before the partial frame is discarded.

Ports:
- clk  in  1  sampling clock (OVS x bit rate).
- reset  in  1  synchronous, active-low.
- rx  in  1  serial line, asynchronous, idle high.
- byte_data  out  8  last received byte.
- byte_valid  out  1  one-cycle pulse: byte_data and byte_idx are valid.
- byte_idx  out  3  position of that byte in the frame (0..BYTES-1).
- frame_done  out  1  one-cycle pulse when the byte at index BYTES-1 is stored.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- timeout  out  1  one-cycle pulse when a partial frame is discarded.
- busy  out  1  high while not in IDLE.
- rd_addr  in  3  buffer read address.
- rd_data  out  8  buffer read data, registered, 1-cycle latency.

Behaviour:
- Reset is synchronous and active-low on reset; clock is clk.
- Reset values: state IDLE; byte_data 0; byte_idx 0; all pulse outputs 0; busy 0; rd_data 0; both rx synchroniser flops 1. Buffer contents are not reset.
- rx passes through a 2-flop synchroniser giving rx_s. T0 is the first cycle with rx_s=0 after a cycle with rx_s=1, detected in IDLE only.
- IDLE -> START at T0; the bit counter is cleared.
- START: at T0+OVS/2, if rx_s=0 go to DATA; if rx_s=1 (glitch) return to IDLE with no outputs.
- DATA: bit n (n=0..7, LSB first) is sampled at T0+OVS/2+(n+1)*OVS. After bit 7, go to STOP.
- STOP sample at T0+OVS/2+9*OVS, rx_s=1:
  - the byte is written to buffer[idx];
  - on the next cycle, byte_data=byte, byte_idx=idx and byte_valid=1;
  - if idx==BYTES-1, frame_done=1 in that same cycle and idx wraps to 0; otherwise idx increments;
  - state -> IDLE.
- STOP sample rx_s=0:
  - no buffer write and no byte_valid;
  - frame_err=1 on the next cycle and idx <= 0;
  - state -> BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. A held-low line never produces a start.
- Timeout counter: cleared at every T0. Counts in IDLE while idx!=0. When it reaches TIMEOUT: idx <= 0, timeout=1 for one cycle, counter cleared. It never fires when idx==0.
- busy=1 in START, DATA, STOP and BREAK.
- Buffer read port: rd_data <= buffer[rd_addr] every cycle. A read and a write to the same address in the same cycle returns the old data.
- Reset asserted mid-byte aborts reception with no pulses. idx returns to 0. Buffer contents are retained.
- Bit timing is not re-synchronised within a byte. The tolerated clock mismatch is therefore set by the OVS/2 margin over 9.5 bits.

Test Plan:
- OVS=16: send 8 bytes 0x01..0x08 back-to-back, 1 stop bit each -> 8 byte_valid pulses with byte_idx 0..7 and byte_data 0x01..0x08. frame_done coincides with the 8th pulse. rd_addr 0..7 then reads 0x01..0x08.
- rx low for 4 cycles, then high -> no byte_valid, no frame_err; busy high for OVS/2 cycles then back to IDLE.
- Byte 0xA5 with stop bit forced 0, then line high -> frame_err pulse and no byte_valid. The next good byte 0x3C arrives with byte_idx 0.
- TIMEOUT=256: send 3 bytes, then idle 300 cycles -> one timeout pulse 256 cycles after the third byte's IDLE entry. The next byte arrives with byte_idx 0.
- Assert reset during bit 4 of the second byte, release, then send 0x55 -> no pulses during the aborted byte. 0x55 arrives with byte_idx 0. Buffer entry 0 is 0x55.
- Hold rx low for 40*OVS cycles after a bad stop bit -> exactly one frame_err and no further activity until rx returns high.
